lift_scheduler: RTL and testbench
=================================

// Module: lift_scheduler
// PURPOSE
//  Parameterised N-floor lift call scheduler (SCAN / elevator algorithm).
//  - Latches active-low call buttons and picks the travel direction.
//  - Drives the motor interface (enable active-low, direction 1 = up).
//  - Holds the door open for a fixed dwell time on arrival.
//  - Sits between the DE0 push-buttons / position sensors and the lift motor model.
//  - Supersedes fixed 3-floor sequencing with a floor-count-independent scheduler.
// PARAMETERS
//  N_FLOORS      4     number of floors, >= 2
//  DWELL_CYCLES  1000  clock cycles the door stays open, >= 2
//  FW            $clog2(N_FLOORS)  floor index width (derived, localparam)
// PORTS
//  clock         in   1         system clock; all state changes on posedge
//  reset         in   1         synchronous, active-high
//  call_n        in   N_FLOORS  call buttons, active-low; bit i = floor i
//  at_floor      in   1         1 = car aligned with floor floor_pos
//  floor_pos     in   FW        current/last floor passed (from position encoder)
//  enable_n      out  1         motor enable, active-low
//  direction     out  1         1 = up, 0 = down; meaningful only while enable_n = 0
//  door_open     out  1         1 while the door dwell is running
//  indicator_n   out  N_FLOORS  call-pending lamps, active-low (0 = pending)
//  busy          out  1         1 when state != IDLE
//  led           out  8         debug: [2:0] state code, [3] dir reg, [7:4] pending[3:0], zero-padded
// BEHAVIOUR
//  Reset (sync, reset = 1 at posedge):
//   - state = IDLE, pending = 0, dir = 0, dwell count = 0.
//   - Outputs: enable_n = 1, direction = 0, door_open = 0, indicator_n = all 1, busy = 0.
//   - Reset mid-travel drops all calls and stops the motor the same cycle the reset is sampled.
//  Call latching:
//   - call_n[i] = 0 sampled at posedge sets pending[i] on the following cycle.
//   - indicator_n = ~pending, so the lamp lags the press by 1 cycle.
//   - Exception: a press for floor_pos while state = DOOR_OPEN is not latched.
//     Instead it restarts the dwell count (door reopen).
//  States (lift_state_t): IDLE, MOVING, DOOR_OPEN.
//  Request queries:
//   - above = |pending[N-1:floor_pos+1]
//   - below = |pending[floor_pos-1:0]
//   - here  = pending[floor_pos] && at_floor
//  IDLE:
//   - here            -> DOOR_OPEN
//   - else above      -> MOVING, dir = 1
//   - else below      -> MOVING, dir = 0
//   - else stay IDLE
//   - Decision is taken in the cycle after pending updates.
//  MOVING:
//   - enable_n = 0 and direction = dir, except when here = 1.
//   - When here = 1, enable_n = 1 combinationally in that same cycle (zero-latency stop), and next state = DOOR_OPEN.
//   - Every pending floor passed is served, regardless of the call's direction.
//  DOOR_OPEN:
//   - On entry: clear pending[floor_pos], load count = DWELL_CYCLES-1.
//   - door_open = 1, enable_n = 1.
//   - Count decrements each cycle; at 0, apply SCAN:
//     - dir = 1 and above -> MOVING (up)
//     - dir = 0 and below -> MOVING (down)
//     - else if the opposite side has a call -> reverse dir, MOVING
//     - else -> IDLE
//   - Door open for exactly DWELL_CYCLES cycles absent reopen.
//  Boundaries:
//   - floor_pos = 0 gives below = 0; floor_pos = N-1 gives above = 0. No out-of-range slice.
//   - A call at the current floor arriving the same cycle MOVING departs is not served here.
//     It is served on the return leg.
//   - Simultaneous calls above and below in IDLE: up wins.
//   - Motor never enabled while door_open = 1.
//   - enable_n is never 0 while at_floor && pending[floor_pos].
// STRUCTURE
//  - Package lift_pkg:
//    - typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} lift_state_t
//    - localparam DIR_UP = 1'b1, DIR_DOWN = 1'b0
//  - Sub-module dwell_timer (#(CYCLES)):
//    - inputs: clock, reset, load
//    - output: done
//    - implements the DOOR_OPEN counter, including reopen restart.
//  - Top keeps the pending register, the above/below reduction logic, the state register
//    (always_ff) and the output decode (always_comb).
// TESTING (N_FLOORS = 4, DWELL_CYCLES = 4)
//  1. Reset while MOVING (enable_n = 0)
//     -> next cycle enable_n = 1, indicator_n = 4'b1111, busy = 0.
//  2. Idle at floor 0, call_n = 4'b0111 (floor 3)
//     -> indicator_n[3] = 0 after 1 cycle, MOVING dir = 1.
//     -> Stops on at_floor at floor_pos = 3; door_open = 1 for exactly 4 cycles; then IDLE.
//  3. Moving up from floor 0 with calls at 2 and 1 pending
//     -> stops at 1, then 2, with no reversal.
//     -> Then a call at 0 reverses dir to 0 after dwell.
//  4. Idle at floor 1, calls at 0 and 3 pressed in the same cycle
//     -> dir = 1, floor 3 served first, then floor 0.
//  5. DOOR_OPEN at floor 2, call_n[2] = 0 on dwell cycle 3
//     -> dwell restarts, door_open total 7 cycles, indicator_n[2] stays 1.
//  6. Idle at floor 2, call_n[2] = 0 with at_floor = 1
//     -> DOOR_OPEN without enable_n ever going 0.

Source files
------------

// File: rtl/lift_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// Package: lift_pkg
// Purpose: Shared types and constants for the lift call scheduler.
//   lift_state_t  controller state (IDLE, MOVING, DOOR_OPEN)
//   DIR_UP        motor direction code for travelling up
//   DIR_DOWN      motor direction code for travelling down
// ----------------------------------------------------------------------------
package lift_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVING    = 2'd1,
        DOOR_OPEN = 2'd2
    } lift_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/lift_scheduler_if.sv
// ----------------------------------------------------------------------------
// Interface: lift_scheduler_if
// Purpose: Bundles the button/sensor inputs and motor/lamp outputs of the
//          lift scheduler so they can be passed around as one port.
// Signals:
//   call_n       call buttons, active-low, bit i = floor i
//   at_floor     1 = car aligned with floor floor_pos
//   floor_pos    current or last floor passed
//   enable_n     motor enable, active-low
//   direction    1 = up, 0 = down (meaningful only while enable_n = 0)
//   door_open    1 while the door dwell is running
//   indicator_n  call-pending lamps, active-low
//   busy         1 when the controller is not idle
//   led          debug: [2:0] state, [3] dir, [7:4] pending[3:0]
// Modports:
//   master  the environment side (buttons, sensors, motor model, lamps)
//   slave   the scheduler side
// ----------------------------------------------------------------------------
interface lift_scheduler_if #(
    parameter int N_FLOORS = 4
);

    localparam int FW = $clog2(N_FLOORS);

    logic [N_FLOORS-1:0] call_n;
    logic                at_floor;
    logic [FW-1:0]       floor_pos;
    logic                enable_n;
    logic                direction;
    logic                door_open;
    logic [N_FLOORS-1:0] indicator_n;
    logic                busy;
    logic [7:0]          led;

    modport master (
        output call_n,
        output at_floor,
        output floor_pos,
        input  enable_n,
        input  direction,
        input  door_open,
        input  indicator_n,
        input  busy,
        input  led
    );

    modport slave (
        input  call_n,
        input  at_floor,
        input  floor_pos,
        output enable_n,
        output direction,
        output door_open,
        output indicator_n,
        output busy,
        output led
    );

endinterface

// File: rtl/lift_scheduler_dwell_timer.sv
// ----------------------------------------------------------------------------
// Module: dwell_timer
// Purpose: Door dwell counter. A load pulse starts (or restarts) a countdown
//          of CYCLES-1 .. 0; done is high while the count sits at zero, so
//          the door stays open for exactly CYCLES cycles after a load.
// Ports:
//   clock   system clock
//   reset   synchronous, active-high; clears the count
//   load    reload the count to CYCLES-1 (door entry or door reopen)
//   done    1 when the count has reached zero
// ----------------------------------------------------------------------------
module dwell_timer #(
    parameter int CYCLES = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic done
);

    localparam int CW = $clog2(CYCLES);

    logic [CW-1:0] count;

    // Countdown register. A load always wins over the decrement so that a
    // reopen request on the final dwell cycle restarts the full dwell rather
    // than letting the car leave. The counter parks at zero when idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(CYCLES - 1);
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/lift_scheduler.sv
// ----------------------------------------------------------------------------
// Module: lift_scheduler
// Purpose: N-floor lift call scheduler using the SCAN (elevator) algorithm.
//          Latches active-low call buttons, chooses the travel direction,
//          drives the motor, and holds the door open for a fixed dwell on
//          arrival at a requested floor.
// Parameters:
//   N_FLOORS      number of floors, >= 2
//   DWELL_CYCLES  clock cycles the door stays open, >= 2
// Ports:
//   clock   system clock, all state changes on posedge
//   reset   synchronous, active-high
//   bus     lift_scheduler_if.slave: call_n, at_floor, floor_pos in;
//           enable_n, direction, door_open, indicator_n, busy, led out
// ----------------------------------------------------------------------------
module lift_scheduler
    import lift_pkg::*;
#(
    parameter int N_FLOORS     = 4,
    parameter int DWELL_CYCLES = 1000
) (
    input  logic               clock,
    input  logic               reset,
    lift_scheduler_if.slave    bus
);

    localparam int FW       = $clog2(N_FLOORS);
    localparam int LED_PEND = (N_FLOORS < 4) ? N_FLOORS : 4;

    lift_state_t         state;
    lift_state_t         state_next;
    logic [N_FLOORS-1:0] pending;
    logic [N_FLOORS-1:0] pending_next;
    logic                dir;
    logic                dir_next;

    logic                above;
    logic                below;
    logic                here;
    logic [N_FLOORS-1:0] press;
    logic                reopen;
    logic                door_entry;
    logic                dwell_load;
    logic                dwell_done;
    logic [3:0]          led_pending;

    // Request queries relative to the current floor. Each floor index is
    // compared against floor_pos instead of slicing the pending vector, so
    // floor 0 naturally has nothing below and the top floor nothing above.
    always_comb begin
        above = 1'b0;
        below = 1'b0;
        here  = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (FW'(i) > bus.floor_pos) begin
                above = above | pending[i];
            end
            if (FW'(i) < bus.floor_pos) begin
                below = below | pending[i];
            end
            if (FW'(i) == bus.floor_pos) begin
                here = here | (pending[i] & bus.at_floor);
            end
        end
    end

    // Button decode. While the door is open, a press for the floor the car
    // is standing at is not a new call: it is a request to keep the door
    // open, so it is diverted into a dwell restart instead of being latched.
    always_comb begin
        press  = ~bus.call_n;
        reopen = 1'b0;
        if (state == DOOR_OPEN) begin
            for (int i = 0; i < N_FLOORS; i++) begin
                if (FW'(i) == bus.floor_pos) begin
                    reopen   = press[i];
                    press[i] = 1'b0;
                end
            end
        end
    end

    // SCAN next-state logic. From IDLE an upward call wins over a downward
    // one. While MOVING the car stops at any pending floor it lines up with,
    // whatever direction the call was for. When the dwell expires the car
    // keeps going the same way while calls remain ahead, otherwise it turns
    // round if there is anything behind it, otherwise it goes idle.
    always_comb begin
        state_next = state;
        dir_next   = dir;
        case (state)
            IDLE: begin
                if (here) begin
                    state_next = DOOR_OPEN;
                end else if (above) begin
                    state_next = MOVING;
                    dir_next   = DIR_UP;
                end else if (below) begin
                    state_next = MOVING;
                    dir_next   = DIR_DOWN;
                end
            end
            MOVING: begin
                if (here) begin
                    state_next = DOOR_OPEN;
                end
            end
            DOOR_OPEN: begin
                if (dwell_done && !reopen) begin
                    if ((dir == DIR_UP) && above) begin
                        state_next = MOVING;
                    end else if ((dir == DIR_DOWN) && below) begin
                        state_next = MOVING;
                    end else if ((dir == DIR_UP) && below) begin
                        state_next = MOVING;
                        dir_next   = DIR_DOWN;
                    end else if ((dir == DIR_DOWN) && above) begin
                        state_next = MOVING;
                        dir_next   = DIR_UP;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pending-call update. New presses accumulate; the call for the floor
    // being served is dropped on the edge that opens the door, so its lamp
    // goes out in the first door-open cycle.
    always_comb begin
        door_entry   = (state != DOOR_OPEN) && (state_next == DOOR_OPEN);
        pending_next = pending | press;
        if (door_entry) begin
            for (int i = 0; i < N_FLOORS; i++) begin
                if (FW'(i) == bus.floor_pos) begin
                    pending_next[i] = 1'b0;
                end
            end
        end
    end

    assign dwell_load = door_entry | reopen;

    dwell_timer #(
        .CYCLES (DWELL_CYCLES)
    ) u_dwell_timer (
        .clock  (clock),
        .reset  (reset),
        .load   (dwell_load),
        .done   (dwell_done)
    );

    // Controller registers. Reset drops every call and returns to IDLE,
    // which takes the motor enable high on the edge the reset is sampled.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            pending <= '0;
            dir     <= DIR_DOWN;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            dir     <= dir_next;
        end
    end

    // Output decode. The motor runs only while MOVING and is cut in the same
    // cycle the car lines up with a pending floor, so it can never be
    // enabled at a served floor or while the door is open.
    always_comb begin
        bus.enable_n    = 1'b1;
        bus.direction   = DIR_DOWN;
        bus.door_open   = 1'b0;
        bus.busy        = (state != IDLE);
        bus.indicator_n = ~pending;
        case (state)
            MOVING: begin
                if (!here) begin
                    bus.enable_n  = 1'b0;
                    bus.direction = dir;
                end
            end
            DOOR_OPEN: begin
                bus.door_open = 1'b1;
            end
            default: begin
                bus.enable_n = 1'b1;
            end
        endcase
    end

    // Debug LEDs: state code, direction register and up to four pending
    // bits, zero-padded when there are fewer than four floors.
    always_comb begin
        led_pending = '0;
        for (int i = 0; i < LED_PEND; i++) begin
            led_pending[i] = pending[i];
        end
        bus.led = {led_pending, dir, 1'b0, state};
    end

endmodule

// File: tb/tb_lift_scheduler.sv
// ----------------------------------------------------------------------------
// Testbench: tb_lift_scheduler
// Purpose: Directed, self-checking bench for lift_scheduler with 4 floors and
//          a 4-cycle dwell. Expected values are queued when stimulus is
//          driven and compared once the design has had its clock edge.
// ----------------------------------------------------------------------------
module tb_lift_scheduler;
    import lift_pkg::*;

    localparam int N  = 4;
    localparam int DW = 4;

    localparam int S_EN      = 0;
    localparam int S_DIR     = 1;
    localparam int S_DOOR    = 2;
    localparam int S_IND     = 3;
    localparam int S_BUSY    = 4;
    localparam int S_STATE   = 5;
    localparam int S_DOORCYC = 6;
    localparam int S_MOTOR   = 7;
    localparam int S_OVERLAP = 8;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] value;
    } exp_t;

    logic clock = 1'b0;
    logic reset;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   door_cycles = 0;
    int   motor_seen = 0;
    int   motor_count = 0;
    int   overlap_count = 0;

    always #5 clock = ~clock;

    lift_scheduler_if #(.N_FLOORS(N)) bus ();

    lift_scheduler #(
        .N_FLOORS     (N),
        .DWELL_CYCLES (DW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Mid-cycle motor monitor: counts cycles with the motor enabled and
    // cycles where it is enabled with the door open.
    always @(negedge clock) begin
        if (bus.enable_n === 1'b0) begin
            motor_count <= motor_count + 1;
            if (bus.door_open === 1'b1) begin
                overlap_count <= overlap_count + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] c, input logic af, input logic [1:0] fp);
        bus.call_n    = c;
        bus.at_floor  = af;
        bus.floor_pos = fp;
    endtask

    task automatic pushExpect(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag   = tag;
        e.sel   = sel;
        e.value = v;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int sel);
        logic [31:0] r;
        r = '0;
        case (sel)
            S_EN:      r = {31'b0, bus.enable_n};
            S_DIR:     r = {31'b0, bus.direction};
            S_DOOR:    r = {31'b0, bus.door_open};
            S_IND:     r = {28'b0, bus.indicator_n};
            S_BUSY:    r = {31'b0, bus.busy};
            S_STATE:   r = {29'b0, bus.led[2:0]};
            S_DOORCYC: r = door_cycles;
            S_MOTOR:   r = motor_seen;
            S_OVERLAP: r = overlap_count;
            default:   r = 'x;
        endcase
        return r;
    endfunction

    task automatic checkOutput();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.value) else begin
                errors++;
                $error("[TB] FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.value);
            end
        end
    endtask

    task automatic checkNow(input string tag, input int sel, input logic [31:0] v);
        pushExpect(tag, sel, v);
        checkOutput();
    endtask

    task automatic measureDoor(output int n);
        int w;
        w = 0;
        while (bus.door_open !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        n = 0;
        while (bus.door_open === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pre;
        int n;
        int motor_base;

        $display("[TB] lift_scheduler directed run starting");

        reset = 1'b1;
        applyStimulus(4'b1111, 1'b1, 2'd0);
        tick();
        tick();
        pushExpect("rst_enable_n", S_EN, 32'd1);
        pushExpect("rst_direction", S_DIR, 32'd0);
        pushExpect("rst_door_open", S_DOOR, 32'd0);
        pushExpect("rst_indicator", S_IND, 32'hF);
        pushExpect("rst_busy", S_BUSY, 32'd0);
        pushExpect("rst_state", S_STATE, 32'(IDLE));
        reset = 1'b0;
        checkOutput();

        $display("[TB] single call to floor 3 from floor 0");
        applyStimulus(4'b0111, 1'b1, 2'd0);
        pushExpect("t2_lamp", S_IND, 32'b0111);
        pushExpect("t2_still_idle", S_BUSY, 32'd0);
        tick();
        checkOutput();
        applyStimulus(4'b1111, 1'b1, 2'd0);
        pushExpect("t2_dir_up", S_DIR, 32'd1);
        pushExpect("t2_motor_on", S_EN, 32'd0);
        pushExpect("t2_moving", S_STATE, 32'(MOVING));
        tick();
        checkOutput();
        applyStimulus(4'b1111, 1'b1, 2'd1);
        tick();
        checkNow("t2_pass_floor1", S_EN, 32'd0);
        applyStimulus(4'b1111, 1'b0, 2'd2);
        tick();
        applyStimulus(4'b1111, 1'b1, 2'd3);
        #1;
        checkNow("t2_zero_latency_stop", S_EN, 32'd1);
        tick();
        checkNow("t2_door_open", S_DOOR, 32'd1);
        checkNow("t2_lamp_clear", S_IND, 32'hF);
        measureDoor(door_cycles);
        checkNow("t2_dwell_len", S_DOORCYC, 32'd4);
        checkNow("t2_back_idle", S_STATE, 32'(IDLE));
        checkNow("t2_not_busy", S_BUSY, 32'd0);

        $display("[TB] reset while moving");
        applyStimulus(4'b1110, 1'b1, 2'd3);
        tick();
        applyStimulus(4'b1111, 1'b1, 2'd3);
        tick();
        checkNow("t1_motor_on", S_EN, 32'd0);
        checkNow("t1_dir_down", S_DIR, 32'd0);
        applyStimulus(4'b1111, 1'b0, 2'd3);
        reset = 1'b1;
        pushExpect("t1_motor_off", S_EN, 32'd1);
        pushExpect("t1_calls_dropped", S_IND, 32'hF);
        pushExpect("t1_not_busy", S_BUSY, 32'd0);
        tick();
        reset = 1'b0;
        checkOutput();

        $display("[TB] up sweep serving floors 1 and 2, then reversal");
        applyStimulus(4'b1111, 1'b1, 2'd0);
        tick();
        applyStimulus(4'b1001, 1'b1, 2'd0);
        tick();
        checkNow("t3_lamps", S_IND, 32'b1001);
        applyStimulus(4'b1111, 1'b1, 2'd0);
        tick();
        checkNow("t3_dir_up", S_DIR, 32'd1);
        checkNow("t3_motor_on", S_EN, 32'd0);
        applyStimulus(4'b1111, 1'b0, 2'd0);
        tick();
        applyStimulus(4'b1111, 1'b1, 2'd1);
        #1;
        checkNow("t3_stop_floor1", S_EN, 32'd1);
        tick();
        checkNow("t3_door_floor1", S_DOOR, 32'd1);
        checkNow("t3_lamp1_clear", S_IND, 32'b1011);
        applyStimulus(4'b1110, 1'b1, 2'd1);
        tick();
        applyStimulus(4'b1111, 1'b1, 2'd1);
        checkNow("t3_lamp0_set", S_IND, 32'b1010);
        tick();
        tick();
        tick();
        checkNow("t3_no_reversal_state", S_STATE, 32'(MOVING));
        checkNow("t3_no_reversal_dir", S_DIR, 32'd1);
        applyStimulus(4'b1111, 1'b0, 2'd1);
        tick();
        applyStimulus(4'b1111, 1'b1, 2'd2);
        tick();
        checkNow("t3_door_floor2", S_DOOR, 32'd1);
        checkNow("t3_lamp2_clear", S_IND, 32'b1110);
        measureDoor(door_cycles);
        checkNow("t3_dwell_floor2", S_DOORCYC, 32'd4);
        checkNow("t3_reverse_dir", S_DIR, 32'd0);
        checkNow("t3_reverse_motor", S_EN, 32'd0);
        applyStimulus(4'b1111, 1'b0, 2'd1);
        tick();
        applyStimulus(4'b1111, 1'b1, 2'd0);
        tick();
        measureDoor(door_cycles);
        checkNow("t3_all_served", S_IND, 32'hF);
        checkNow("t3_idle", S_BUSY, 32'd0);

        $display("[TB] simultaneous calls above and below from floor 1");
        applyStimulus(4'b1111, 1'b1, 2'd1);
        tick();
        applyStimulus(4'b0110, 1'b1, 2'd1);
        tick();
        checkNow("t4_lamps", S_IND, 32'b0110);
        applyStimulus(4'b1111, 1'b1, 2'd1);
        tick();
        checkNow("t4_up_wins", S_DIR, 32'd1);
        checkNow("t4_motor_on", S_EN, 32'd0);
        applyStimulus(4'b1111, 1'b0, 2'd2);
        tick();
        applyStimulus(4'b1111, 1'b1, 2'd3);
        tick();
        checkNow("t4_floor3_first", S_DOOR, 32'd1);
        checkNow("t4_floor0_still_pending", S_IND, 32'b1110);
        measureDoor(door_cycles);
        checkNow("t4_reverse_dir", S_DIR, 32'd0);
        checkNow("t4_reverse_motor", S_EN, 32'd0);
        applyStimulus(4'b1111, 1'b0, 2'd2);
        tick();
        applyStimulus(4'b1111, 1'b0, 2'd1);
        tick();
        applyStimulus(4'b1111, 1'b1, 2'd0);
        tick();
        checkNow("t4_floor0_door", S_DOOR, 32'd1);
        checkNow("t4_floor0_lamp", S_IND, 32'hF);
        measureDoor(door_cycles);
        checkNow("t4_idle", S_BUSY, 32'd0);

        $display("[TB] door reopen at floor 2");
        applyStimulus(4'b1011, 1'b1, 2'd0);
        tick();
        applyStimulus(4'b1111, 1'b1, 2'd0);
        tick();
        applyStimulus(4'b1111, 1'b0, 2'd1);
        tick();
        applyStimulus(4'b1111, 1'b1, 2'd2);
        tick();
        pre = 0;
        for (int k = 0; k < 3; k++) begin
            if (bus.door_open === 1'b1) begin
                pre++;
            end
            if (k == 2) begin
                applyStimulus(4'b1011, 1'b1, 2'd2);
            end
            tick();
        end
        applyStimulus(4'b1111, 1'b1, 2'd2);
        checkNow("t5_lamp_stays_off", S_IND, 32'hF);
        measureDoor(n);
        door_cycles = pre + n;
        checkNow("t5_total_dwell", S_DOORCYC, 32'd7);
        checkNow("t5_idle", S_STATE, 32'(IDLE));

        $display("[TB] call at the current floor while idle");
        motor_base = motor_count;
        applyStimulus(4'b1011, 1'b1, 2'd2);
        tick();
        applyStimulus(4'b1111, 1'b1, 2'd2);
        checkNow("t6_lamp", S_IND, 32'b1011);
        checkNow("t6_motor_held", S_EN, 32'd1);
        tick();
        checkNow("t6_door_open", S_DOOR, 32'd1);
        measureDoor(door_cycles);
        checkNow("t6_dwell_len", S_DOORCYC, 32'd4);
        motor_seen = motor_count - motor_base;
        checkNow("t6_motor_never_on", S_MOTOR, 32'd0);
        checkNow("motor_with_door_open", S_OVERLAP, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
